// File: rtl/ntt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ntt_pkg : shared types and sizes for the NTT butterfly scheduler |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`ifndef RING_SIZE
`define RING_SIZE 8
`endif

package ntt_pkg;
  localparam int RING_SIZE = `RING_SIZE;
  localparam int LOG_N     = $clog2(RING_SIZE);
  localparam int HALF_N    = RING_SIZE / 2;
  localparam int STAGE_W   = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef logic [LOG_N-1:0] ntt_idx_t;

  typedef struct packed {
    logic     valid;
    ntt_idx_t idx_a;
    ntt_idx_t idx_b;
  } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/ntt_wb_delay.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ntt_wb_delay : fixed-depth delay line of write-back entries      |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module ntt_wb_delay
  import ntt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  wb_entry_t din,
  output wb_entry_t dout
);
  wb_entry_t taps [DEPTH+1];

  assign taps[0] = din;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    wb_entry_t q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= '0;
      else        q <= taps[g];
    end
    assign taps[g+1] = q;
  end

  assign dout = taps[DEPTH];
endmodule
`default_nettype wire

// File: rtl/ntt_butterfly_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ntt_butterfly_scheduler : in-place radix-2 DIT NTT issue control |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module ntt_butterfly_scheduler
  import ntt_pkg::*;
#(
  parameter int PIPE_LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_done,
  input  logic               bf_ready,
  output logic               bf_valid,
  output logic [LOG_N-1:0]   idx_a,
  output logic [LOG_N-1:0]   idx_b,
  output logic               bank_a,
  output logic               bank_b,
  output logic [LOG_N-2:0]   addr_a,
  output logic [LOG_N-2:0]   addr_b,
  output logic [LOG_N-2:0]   tw_idx,
  output logic [STAGE_W-1:0] stage,
  output logic               wb_valid,
  output logic [LOG_N-1:0]   wb_idx_a,
  output logic [LOG_N-1:0]   wb_idx_b,
  output logic               busy,
  output logic               ntt_done
);
  localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  typedef logic [LOG_N-2:0] k_t;

  sched_state_t        state, state_nxt;
  k_t                  k, k_nxt, lowk;
  logic [STAGE_W-1:0]  s, s_nxt;
  logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
  logic                load_q, armed, start, accept;
  ntt_idx_t            kx, half, ia;
  wb_entry_t           wb_in, wb_out;

  // armed requires load_done to be seen low after reset, so a level held
  // high across reset release cannot masquerade as a fresh rising edge
  assign start  = load_done & ~load_q & armed;
  assign accept = bf_valid & bf_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      k      <= '0;
      s      <= '0;
      dcnt   <= '0;
      load_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      s      <= s_nxt;
      dcnt   <= dcnt_nxt;
      load_q <= load_done;
      armed  <= armed | ~load_done;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    s_nxt     = s;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        k_nxt     = '0;
        s_nxt     = '0;
      end
      RUN: if (accept) begin
        k_nxt = k + 1'b1;
        if (k == k_t'(HALF_N - 1)) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end
      end
      DRAIN: begin
        if (dcnt == DCNT_W'(PIPE_LAT - 1)) begin
          if (s == STAGE_W'(LOG_N - 1)) begin
            state_nxt = DONE;
          end else begin
            s_nxt     = s + 1'b1;
            k_nxt     = '0;
            state_nxt = RUN;
          end
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      DONE: if (!load_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue fields are forced to zero outside RUN so reset and idle read as 0
  always_comb begin
    kx       = ntt_idx_t'(k);
    half     = ntt_idx_t'(1) << s;
    lowk     = k & k_t'(half - ntt_idx_t'(1));
    ia       = (((kx >> s) << 1) << s) | ntt_idx_t'(lowk);
    bf_valid = (state == RUN);
    busy     = (state == RUN) || (state == DRAIN);
    ntt_done = (state == DONE);
    stage    = s;
    idx_a    = bf_valid ? ia : '0;
    idx_b    = bf_valid ? (ia | half) : '0;
    tw_idx   = bf_valid ? (lowk << (LOG_N - 1 - int'(s))) : '0;
  end

  assign bank_a = idx_a[LOG_N-1];
  assign bank_b = idx_b[LOG_N-1];
  assign addr_a = idx_a[LOG_N-2:0];
  assign addr_b = idx_b[LOG_N-2:0];

  assign wb_in.valid = accept;
  assign wb_in.idx_a = accept ? idx_a : '0;
  assign wb_in.idx_b = accept ? idx_b : '0;

  ntt_wb_delay #(
    .DEPTH (PIPE_LAT)
  ) u_wb_delay (
    .clk   (clk),
    .reset (reset),
    .din   (wb_in),
    .dout  (wb_out)
  );

  assign wb_valid = wb_out.valid;
  assign wb_idx_a = wb_out.idx_a;
  assign wb_idx_b = wb_out.idx_b;
endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_ntt_butterfly_scheduler : self-checking bench for scheduler   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_ntt_butterfly_scheduler;
  import ntt_pkg::*;

  localparam int P = 2;
  localparam int N = RING_SIZE;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_done;
  logic               bf_ready;
  logic               bf_valid;
  logic [LOG_N-1:0]   idx_a, idx_b;
  logic               bank_a, bank_b;
  logic [LOG_N-2:0]   addr_a, addr_b;
  logic [LOG_N-2:0]   tw_idx;
  logic [STAGE_W-1:0] stage;
  logic               wb_valid;
  logic [LOG_N-1:0]   wb_idx_a, wb_idx_b;
  logic               busy, ntt_done;

  int errors = 0;
  int checks = 0;

  typedef struct { int a; int b; int tw; int st; } exp_t;
  typedef struct { int a; int b; int due; } wbe_t;

  always #5 clk = ~clk;

  ntt_butterfly_scheduler #(
    .PIPE_LAT (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_done (load_done),
    .bf_ready  (bf_ready),
    .bf_valid  (bf_valid),
    .idx_a     (idx_a),
    .idx_b     (idx_b),
    .bank_a    (bank_a),
    .bank_b    (bank_b),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .wb_valid  (wb_valid),
    .wb_idx_a  (wb_idx_a),
    .wb_idx_b  (wb_idx_b),
    .busy      (busy),
    .ntt_done  (ntt_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bf_valid"}, bf_valid, 0);
    chk({tag, "_idx_a"}, idx_a, 0);
    chk({tag, "_idx_b"}, idx_b, 0);
    chk({tag, "_tw"}, tw_idx, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_wb"}, {wb_valid, wb_idx_a, wb_idx_b}, 0);
    chk({tag, "_busy_done"}, {busy, ntt_done}, 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: 1,0,0,1 stall in stage 1,
  // 3: always ready with a second load_done rising edge while running
  task automatic run_transform(input int mode, input int abort_at);
    exp_t expq[$];
    wbe_t wbq[$];
    int   acc = 0, stalls = 0, gap = 0, done_cyc = -1;
    bit   prev_v = 0, prev_r = 0, aborted = 0;
    int   pa = 0, pb = 0, pt = 0;

    for (int s = 0; s < LOG_N; s++) begin
      int h = 1 << s;
      for (int j = 0; j < N; j += 2 * h)
        for (int m = 0; m < h; m++)
          expq.push_back('{a: j + m, b: j + m + h, tw: m * (N / (2 * h)), st: s});
    end

    load_done = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == abort_at) begin
        #1 reset = 1'b0;
        #1;
        chk_all_zero("abort");
        aborted = 1;
        break;
      end
      if (ntt_done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == 0) chk("first_valid", bf_valid, 1);
      chk("busy_run", busy, 1);

      if (wbq.size() > 0 && wbq[0].due == cyc) begin
        chk("wb_valid", wb_valid, 1);
        chk("wb_idx_a", wb_idx_a, wbq[0].a);
        chk("wb_idx_b", wb_idx_b, wbq[0].b);
        void'(wbq.pop_front());
      end else begin
        chk("wb_idle", wb_valid, 0);
      end

      if (bf_valid) begin
        if (mode == 0 && gap > 0) chk("drain_gap", gap, P);
        gap = 0;
        chk("issue_pending", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          chk("idx_a", idx_a, expq[0].a);
          chk("idx_b", idx_b, expq[0].b);
          chk("tw_idx", tw_idx, expq[0].tw);
          chk("stage", stage, expq[0].st);
          chk("bank_b", bank_b, expq[0].b / HALF_N);
          chk("addr_b", addr_b, expq[0].b % HALF_N);
          chk("bank_addr_a", {bank_a, addr_a}, expq[0].a);
        end
        if (prev_v && !prev_r) begin
          chk("hold_a", idx_a, pa);
          chk("hold_b", idx_b, pb);
          chk("hold_tw", tw_idx, pt);
        end
      end else begin
        gap++;
      end

      case (mode)
        1: bf_ready = ($urandom_range(0, 3) != 0);
        2: if (acc == 5 && stalls < 2) begin bf_ready = 1'b0; stalls++; end
           else bf_ready = 1'b1;
        default: bf_ready = 1'b1;
      endcase
      if (mode == 3 && cyc == 1) load_done = 1'b0;
      if (mode == 3 && cyc == 2) load_done = 1'b1;

      prev_v = bf_valid;
      prev_r = bf_ready;
      pa = idx_a; pb = idx_b; pt = tw_idx;
      if (bf_valid && bf_ready) begin
        if (expq.size() > 0) begin
          wbq.push_back('{a: expq[0].a, b: expq[0].b, due: cyc + P});
          void'(expq.pop_front());
        end
        acc++;
      end
      @(posedge clk); #1;
    end

    if (!aborted) begin
      chk("done_seen", done_cyc >= 0, 1);
      chk("acceptances", acc, LOG_N * HALF_N);
      chk("wb_drained", wbq.size(), 0);
      if (mode == 0) begin
        chk("done_latency", done_cyc, LOG_N * (HALF_N + P));
        chk("last_drain", gap, P);
      end
      chk("done_idle_outputs", {bf_valid, busy}, 0);
      repeat (2) @(posedge clk);
      #1 chk("done_held", ntt_done, 1);
      load_done = 1'b0;
      @(posedge clk); #1;
      chk("done_cleared", ntt_done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    load_done = 1'b0;
    bf_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    run_transform(0, -1);
    run_transform(2, -1);
    run_transform(3, -1);

    run_transform(0, HALF_N + P + 1);
    repeat (2) @(posedge clk);
    #1 chk_all_zero("in_reset");
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_restart_valid", bf_valid, 0);
    chk("no_restart_busy", busy, 0);
    load_done = 1'b0;
    @(posedge clk); #1;

    run_transform(1, -1);
    run_transform(1, -1);
    run_transform(0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ntt_butterfly_scheduler.md
Name: ntt_butterfly_scheduler

Overview:
- Control stage directly downstream of the bit-reversed load stage, which writes RING_SIZE coefficients into two RAM banks at bit-reversed positions (bank = index MSB, local address = low bits) and then raises its load-complete flag.
- Runs an in-place radix-2 Cooley-Tukey DIT NTT over those banks: for each of LOG_N stages it issues RING_SIZE/2 butterflies (operand index pair plus twiddle index) to the butterfly datapath under a valid/ready handshake.
- Emits matching write-back addresses a fixed PIPE_LAT cycles after each accepted butterfly.
- Raises ntt_done when every stage has been issued and drained.

Parameters:
RING_SIZE, `RING_SIZE, transform length N (power of two, >= 4)
LOG_N, $clog2(RING_SIZE), index width (derived; not overridden)
PIPE_LAT, 4, fixed butterfly-datapath latency in cycles (>= 1)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-low (0 = in reset)
load_done  input  1  load-complete level from the load stage; a rising edge starts a transform
bf_ready  input  1  butterfly datapath can accept an issue this cycle
bf_valid  output  1  issue fields valid
idx_a  output  LOG_N  global index of the upper operand
idx_b  output  LOG_N  global index of the lower operand
bank_a, bank_b  output  1 each  bank select (0 = ram1, 1 = ram2) = idx MSB
addr_a, addr_b  output  LOG_N-1 each  local bank address = idx[LOG_N-2:0]
tw_idx  output  LOG_N-1  twiddle-ROM index
stage  output  $clog2(LOG_N)  current stage number
wb_valid  output  1  write-back of results is due this cycle
wb_idx_a, wb_idx_b  output  LOG_N each  write-back indices
busy  output  1  high in RUN or DRAIN
ntt_done  output  1  transform complete (level)

Behaviour:
- Reset, async: every output is 0, state = IDLE, all counters 0, shift register cleared, the registered copy of load_done is 0. An assertion mid-transform aborts it immediately; no partial done is produced.
- The start event is a rising edge of load_done, detected against a registered copy. Start events are honoured only in IDLE and ignored everywhere else.
- FSM:
  - IDLE -> RUN on a start event. Clears k (LOG_N-1 bits) and s.
  - RUN: bf_valid = 1. An issue is accepted when bf_valid && bf_ready at the clock edge.
    - All issue fields stay stable while bf_valid && !bf_ready.
    - On acceptance k increments. If k was N/2-1, the state goes to DRAIN and the drain counter is cleared.
  - DRAIN: bf_valid = 0 for exactly PIPE_LAT cycles.
    - Then, if s < LOG_N-1: s++, k = 0, state -> RUN.
    - Otherwise state -> DONE.
  - DONE: ntt_done = 1. Leaves for IDLE when load_done is sampled low.
- Issue arithmetic, with half = 1<<s:
  - idx_a = k with a 0 bit inserted at bit position s, i.e. ((k>>s)<<(s+1)) | (k & (half-1)).
  - idx_b = idx_a | half.
  - tw_idx = (k & (half-1)) << (LOG_N-1-s). Shift is done in LOG_N-1 bits; no overflow is possible.
- Write-back:
  - A PIPE_LAT-deep shift register of {valid, idx_a, idx_b}.
  - An entry is pushed on every accepted issue and a bubble on every other cycle.
  - wb_* outputs are the register tail, so wb_valid fires exactly PIPE_LAT cycles after the corresponding acceptance.
  - The datapath is non-stalling once an issue is accepted.
- The DRAIN length of PIPE_LAT guarantees the last write-back of stage s completes before the first read of stage s+1. This is the RAW hazard rule.
- With bf_ready held high:
  - bf_valid first asserts the cycle after the start edge is sampled.
  - The transform takes LOG_N*(N/2+PIPE_LAT) cycles from then to ntt_done.
- busy = (state==RUN || state==DRAIN).

Decomposition:
- Shared package ntt_pkg holds:
  - typedef enum {IDLE, RUN, DRAIN, DONE} sched_state_t
  - typedef logic [LOG_N-1:0] ntt_idx_t
  - typedef struct {valid, idx_a, idx_b} wb_entry_t
  - constants HALF_N = RING_SIZE/2 and LOG_N
- One sub-module, ntt_wb_delay: the PIPE_LAT-stage shift register of wb_entry_t, with asynchronous active-low clear.
- The FSM, counters and index arithmetic stay in the top level.

Test Plan:
- RING_SIZE=8, PIPE_LAT=2, bf_ready=1, load_done 0->1:
  - stage0 issues (0,1),(2,3),(4,5),(6,7), all tw 0.
  - stage1 issues (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2.
  - stage2 issues (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3.
  - bank_b=1, addr_b=3 on (3,7).
  - ntt_done rises 18 cycles after the first bf_valid.
- Same setup: each wb_valid pulse appears exactly 2 cycles after its acceptance with identical indices. bf_valid is low for 2 cycles between stages.
- bf_ready toggled 1,0,0,1 during stage1:
  - idx_a/idx_b/tw_idx hold (1,3,2) through the stall.
  - No issue is skipped or duplicated; 12 total acceptances.
- Reset pulled to 0 mid-stage1:
  - All outputs are 0 immediately (asynchronous).
  - After release with load_done still high, no restart occurs.
  - A new start occurs only after load_done goes low then high again.
- Second rising edge of load_done while in RUN: ignored and the issue sequence is unchanged. DONE -> IDLE only after load_done is sampled low.
- RING_SIZE=256, PIPE_LAT=4, randomized bf_ready:
  - 1024 acceptances.
  - Every index 0..255 appears exactly once per stage across idx_a/idx_b.
  - tw_idx matches the formula.
